// File: rtl/rv32i_types.sv
// rv32i_types: types shared across the RV32I pipeline.
//   mau_state_t     - state encoding of the memory-access unit handshake FSM
//   load_funct3_t   - funct3 encodings of the load instructions
//   store_funct3_t  - funct3 encodings of the store instructions
//   access_misaligned() - true when a half/word access is not naturally aligned
package rv32i_types;

  typedef enum logic {MAU_IDLE, MAU_BUSY} mau_state_t;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  // Loads and stores share the access size in funct3[1:0], so one check covers both.
  function automatic logic access_misaligned(input logic [2:0] funct3,
                                             input logic [1:0] offset);
    case (funct3[1:0])
      2'b01:   return offset[0];
      2'b10:   return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: combinational load-data extraction for the MEM stage.
//   rdata_i  [31:0] raw word returned by the data cache
//   offset_i [1:0]  byte offset of the access within the word
//   funct3_i [2:0]  load_funct3_t encoding (lb/lh/lw/lbu/lhu)
//   data_o   [31:0] selected lane, sign- or zero-extended to 32 bits
module load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  // Shift the addressed byte down to lane 0; the upper lanes fill with zeros, so a
  // halfword read at offset 3 naturally sees 0 in its top byte.
  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    data_o  = shifted;
    case (load_funct3_t'(funct3_i))
      lb:      data_o = {{24{shifted[7]}}, shifted[7:0]};
      lbu:     data_o = {24'h000000, shifted[7:0]};
      lh:      data_o = {{16{shifted[15]}}, shifted[15:0]};
      lhu:     data_o = {16'h0000, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage of the RV32I pipeline.
// Drives the data-cache request/response handshake, aligns store data, extracts
// load data, stalls the front of the pipe until the cache answers, and registers
// the result into MEM/WB.
// Optional feature macro: MAU_MISALIGN_CHK_EN (flag misaligned half/word accesses
// instead of issuing them).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ex_valid/ex_load/ex_store      EX/MEM slot qualifiers
//   ex_funct3, ex_addr, ex_wdata   access encoding, effective address, store data
//   ex_mbe, ex_rd                  byte enable, destination register
//   dmem_rdata, dmem_resp          cache read data and completion strobe
//   dmem_read/write/address/wdata/mbe  cache request
//   ma_stall                       freeze IF..EX/MEM this cycle
//   wb_valid, wb_rd, wb_data, wb_misalign  MEM/WB register outputs
module mem_access_unit
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_mbe,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  output logic        ma_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_misalign
);

  mau_state_t  state_q, state_d;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_misalign_q;

  logic        mem_op;
  logic        misalign;
  logic        req;
  logic [31:0] store_data;
  logic [31:0] load_data;

  assign mem_op = ex_valid & (ex_load | ex_store);

`ifdef MAU_MISALIGN_CHK_EN
  assign misalign = mem_op & access_misaligned(ex_funct3, ex_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // A misaligned access is retired without touching the cache; reset silences any request.
  assign req = mem_op & ~misalign & ~rst;

  // Replicate the store value across every lane it could land in; the byte enable
  // picks the lane, so no shift by the offset is needed.
  always_comb begin
    store_data = ex_wdata;
    case (store_funct3_t'(ex_funct3))
      sb:      store_data = {4{ex_wdata[7:0]}};
      sh:      store_data = {2{ex_wdata[15:0]}};
      default: store_data = ex_wdata;
    endcase
  end

  load_align u_load_align (
    .rdata_i  (dmem_rdata),
    .offset_i (ex_addr[1:0]),
    .funct3_i (ex_funct3),
    .data_o   (load_data)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= MAU_IDLE;
    else     state_q <= state_d;
  end

  // Request outputs follow the held EX/MEM inputs, so they stay stable through BUSY
  // without re-latching. The FSM only tracks whether a request is outstanding.
  always_comb begin
    state_d      = state_q;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_address = 32'h0;
    dmem_wdata   = 32'h0;
    dmem_mbe     = 4'h0;
    ma_stall     = req & ~dmem_resp;
    if (req) begin
      dmem_read    = ex_load;
      dmem_write   = ex_store;
      dmem_address = {ex_addr[31:2], 2'b00};
      dmem_wdata   = store_data;
      dmem_mbe     = ex_mbe;
    end
    case (state_q)
      MAU_IDLE: if (req && !dmem_resp) state_d = MAU_BUSY;
      MAU_BUSY: if (dmem_resp || !req) state_d = MAU_IDLE;
      default:  state_d = MAU_IDLE;
    endcase
  end

  // Writeback value: zero for a flagged misaligned access, loaded data for loads,
  // otherwise the ALU result carried in ex_addr.
  always_comb begin
    wb_data_d = ex_addr;
    if (misalign)     wb_data_d = 32'h0;
    else if (ex_load) wb_data_d = load_data;
  end

  // MEM/WB register: advances on every non-stalled cycle and simply holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= 32'h0;
      wb_misalign_q <= 1'b0;
    end else if (!ma_stall) begin
      wb_valid_q    <= ex_valid;
      wb_rd_q       <= ex_rd;
      wb_data_q     <= wb_data_d;
      wb_misalign_q <= misalign;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign wb_misalign = wb_misalign_q;

endmodule
